// File: rtl/rs_latch_arbiter_pkg.sv
// Shared types and helpers for the RS-latch arbiter: FSM states, operation codes
// and a small integer helper used to size the phase counter.
package rs_latch_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rs_latch_arbiter_if.sv
// Requester-side bus of the RS-latch arbiter: per-requester set/clear levels
// and the one-cycle acknowledge returned when an operation completes.
interface rs_latch_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] set_req;
    logic [N_REQ-1:0] clr_req;
    logic [N_REQ-1:0] ack;

    modport master (output set_req, output clr_req, input ack);
    modport slave  (input set_req, input clr_req, output ack);
endinterface

// File: rtl/rs_latch_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping)
// wins. The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    // Scan requesters starting at the pointer; the first hit suppresses the rest.
    always_comb begin : arb_scan
        int   idx;
        logic hit;
        idx       = 0;
        hit       = 1'b0;
        grant     = {N{1'b0}};
        grant_idx = {$clog2(N){1'b0}};
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx        = (int'(ptr) + k) % N;
            hit        = !any && req[idx];
            grant[idx] = hit;
            grant_idx  = hit ? idx[$clog2(N)-1:0] : grant_idx;
            any        = any | hit;
        end
    end

endmodule

// File: rtl/rs_latch_arbiter.sv
// Shares one NAND RS latch among N_REQ requesters: grants round-robin, drives a
// timed active-low set or reset pulse, checks q after a quiet gap, then acks.
module rs_latch_arbiter
    import rs_latch_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                clk,
    input  logic                nrst,
    rs_latch_arbiter_if.slave   req_bus,
    output logic                ns,
    output logic                nr,
    input  logic                q_in,
    output logic                busy,
    output logic                err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [IW-1:0]    grant_idx_r, grant_idx_s;
    logic [IW-1:0]    ptr_r, ptr_s;
    logic             op_r, op_s;
    logic [N_REQ-1:0] ack_r, ack_s;
    logic             err_r, err_s;
    logic             ns_r, nr_r, busy_r;

    logic [N_REQ-1:0] active_s;
    logic [N_REQ-1:0] arb_grant_s;
    logic [IW-1:0]    arb_idx_s;
    logic             arb_any_s;

    assign active_s = req_bus.set_req | req_bus.clr_req;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req       (active_s),
        .ptr       (ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .any       (arb_any_s)
    );

    // Next-state, grant capture, pointer update and completion flags.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        grant_idx_s = grant_idx_r;
        ptr_s       = ptr_r;
        op_s        = op_r;
        ack_s       = {N_REQ{1'b0}};
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    state_s     = ST_PULSE;
                    cnt_s       = {CW{1'b0}};
                    grant_idx_s = arb_idx_s;
                    // Clear dominates when a requester asks for both.
                    op_s        = (|(arb_grant_s & req_bus.clr_req)) ? OP_CLR : OP_SET;
                    ptr_s       = (arb_idx_s == IW'(N_REQ - 1)) ? {IW{1'b0}} : arb_idx_s + IW'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == CW'(PULSE_CYCLES - 1)) begin
                    state_s = ST_GAP;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_r == CW'(GAP_CYCLES - 1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                    ack_s   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_r;
                    // Expected q equals the op code: 1 after SET, 0 after CLR.
                    err_s   = (q_in != op_r);
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, grant and output registers; latch pins are derived from the next state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            grant_idx_r <= {IW{1'b0}};
            ptr_r       <= {IW{1'b0}};
            op_r        <= OP_CLR;
            ack_r       <= {N_REQ{1'b0}};
            err_r       <= 1'b0;
            ns_r        <= 1'b1;
            nr_r        <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            grant_idx_r <= grant_idx_s;
            ptr_r       <= ptr_s;
            op_r        <= op_s;
            ack_r       <= ack_s;
            err_r       <= err_s;
            ns_r        <= ~((state_s == ST_PULSE) && (op_s == OP_SET));
            nr_r        <= ~((state_s == ST_PULSE) && (op_s == OP_CLR));
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign req_bus.ack = ack_r;
    assign ns          = ns_r;
    assign nr          = nr_r;
    assign busy        = busy_r;
    assign err         = err_r;

endmodule

// File: tb/tb_rs_latch_arbiter.sv
// Bench for rs_latch_arbiter: behavioural NAND latch on ns/nr, a timeline model
// that queues expected acks, and a negedge monitor that checks every cycle.
module tb_rs_latch_arbiter;

    localparam int N = 4;
    localparam int P = 2;
    localparam int G = 1;

    logic clk = 1'b0;
    logic nrst;
    logic ns, nr, busy, err, q_in;
    logic latch_q  = 1'b0;
    logic force_q0 = 1'b0;

    rs_latch_arbiter_if #(.N_REQ(N)) bus ();

    rs_latch_arbiter #(.N_REQ(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .req_bus (bus),
        .ns      (ns),
        .nr      (nr),
        .q_in    (q_in),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // NAND latch: low set forces q=1, low reset forces q=0, otherwise hold.
    always @(ns or nr) begin
        if (ns === 1'b0) latch_q = 1'b1;
        else if (nr === 1'b0) latch_q = 1'b0;
    end
    assign q_in = force_q0 ? 1'b0 : latch_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    typedef struct {
        int   idx;
        logic err;
        int   edge_no;
    } exp_t;
    exp_t exp_q[$];

    int   edge_n   = 0;
    bit   m_active = 1'b0;
    int   m_g      = 0;
    bit   m_set    = 1'b0;
    int   m_ptr    = 0;

    // Reference timeline: an operation granted at edge g occupies edges g..g+P+G.
    initial begin
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) begin
                m_active = 1'b0;
                m_ptr    = 0;
                exp_q.delete();
            end else begin
                edge_n++;
                if (!m_active || edge_n > m_g + P + G) begin
                    logic [N-1:0] act;
                    int w;
                    act = bus.set_req | bus.clr_req;
                    w   = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && act[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                    if (w >= 0) begin
                        exp_t e;
                        m_set    = !bus.clr_req[w];
                        m_g      = edge_n;
                        m_active = 1'b1;
                        m_ptr    = (w + 1) % N;
                        e.idx     = w;
                        e.err     = force_q0 && m_set;
                        e.edge_no = edge_n + P + G;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    // Monitor: latch pins, busy, ack and err against the model every cycle.
    initial begin
        forever begin
            logic in_pulse, in_op;
            @(negedge clk);
            in_pulse = m_active && edge_n >= m_g && edge_n < m_g + P;
            in_op    = m_active && edge_n >= m_g && edge_n < m_g + P + G;
            chk("ns_nr_not_both_low", 32'(ns | nr), 32'd1);
            chk("ns_level", 32'(ns), 32'(!(in_pulse && m_set)));
            chk("nr_level", 32'(nr), 32'(!(in_pulse && !m_set)));
            chk("busy_level", 32'(busy), 32'(in_op));
            if (exp_q.size() > 0 && exp_q[0].edge_no == edge_n) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_onehot", 32'(bus.ack), 32'(1) << e.idx);
                chk("err_at_ack", 32'(err), 32'(e.err));
            end else begin
                chk("ack_idle", 32'(bus.ack), 32'd0);
                chk("err_idle", 32'(err), 32'd0);
            end
        end
    end

    task automatic wait_ack(output int idx, output int lat, output logic err_seen);
        bit done;
        done     = 1'b0;
        idx      = -1;
        lat      = 0;
        err_seen = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.ack != '0) begin
                done     = 1'b1;
                err_seen = err;
                for (int b = 0; b < N; b++) if (bus.ack[b]) idx = b;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: no ack within 20 cycles, got none expected one");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int   idx, lat;
        logic e;
        logic q_before;
        int   order_exp [5];
        order_exp = '{0, 1, 2, 3, 0};

        nrst        = 1'b0;
        bus.set_req = '0;
        bus.clr_req = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ns", 32'(ns), 32'd1);
        chk("reset_nr", 32'(nr), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack", 32'(bus.ack), 32'd0);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single SET from requester 0: latency and resulting q.
        bus.set_req = 4'b0001;
        wait_ack(idx, lat, e);
        bus.set_req = 4'b0000;
        chk("set0_ack_idx", 32'(idx), 32'd0);
        chk("set0_latency", 32'(lat), 32'(1 + P + G));
        chk("set0_err", 32'(e), 32'd0);
        chk("set0_q", 32'(latch_q), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Set and clear together on requester 2: clear wins.
        bus.set_req = 4'b0100;
        bus.clr_req = 4'b0100;
        wait_ack(idx, lat, e);
        bus.set_req = 4'b0000;
        bus.clr_req = 4'b0000;
        chk("both2_ack_idx", 32'(idx), 32'd2);
        chk("both2_q", 32'(latch_q), 32'd0);
        chk("both2_err", 32'(e), 32'd0);
        @(posedge clk);
        #1;
        chk("both2_single_ack", 32'(bus.ack), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // q forced low after a SET: err only in the ack cycle.
        force_q0    = 1'b1;
        bus.set_req = 4'b0001;
        wait_ack(idx, lat, e);
        bus.set_req = 4'b0000;
        chk("forced_err", 32'(e), 32'd1);
        @(posedge clk);
        #1;
        force_q0 = 1'b0;
        chk("forced_err_one_cycle", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted mid-pulse of a CLR on requester 1.
        bus.clr_req = 4'b0010;
        @(posedge clk);
        #1;
        chk("midpulse_nr_low", 32'(nr), 32'd0);
        q_before = latch_q;
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_ns", 32'(ns), 32'd1);
        chk("midrst_nr", 32'(nr), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack", 32'(bus.ack), 32'd0);
        chk("midrst_q_kept", 32'(latch_q), 32'(q_before));
        bus.clr_req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;

        // All requesters held: strict rotation from pointer 0.
        bus.set_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(idx, lat, e);
            chk("rr_order", 32'(idx), 32'(order_exp[k]));
        end
        bus.set_req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;

        // Randomised requesters: raise, hold, withdraw, re-request after ack.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) begin
                    if ($urandom_range(3) != 0) begin
                        bus.set_req[i] = 1'b0;
                        bus.clr_req[i] = 1'b0;
                    end
                end else if (!(bus.set_req[i] | bus.clr_req[i])) begin
                    if ($urandom_range(5) == 0) begin
                        int r;
                        r = $urandom_range(2);
                        bus.set_req[i] = (r != 1);
                        bus.clr_req[i] = (r != 0);
                    end
                end else if ($urandom_range(39) == 0) begin
                    bus.set_req[i] = 1'b0;
                    bus.clr_req[i] = 1'b0;
                end
            end
        end
        bus.set_req = '0;
        bus.clr_req = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
